// File: rtl/spi_byte_rx_pkg.sv
// Shared SPI byte-receiver definitions: byte width, default counter width, byte type.
package spi_byte_rx_pkg;
  localparam int BYTE_W         = 8;
  localparam int BYTE_CNT_W_DEF = 16;

  typedef logic [BYTE_W-1:0] spi_byte_t;
endpackage

// File: rtl/spi_byte_rx_edge_detect.sv
// Level history and edge detection for a synchronized 1-bit input.
// History resets to 1 so a line held low through reset reads as a falling edge.
module spi_byte_rx_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o,
  output logic pos_pulse_o,
  output logic neg_pulse_o
);
  logic sig_q;

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sig_q       <= 1'b1;
      pos_pulse_o <= 1'b0;
      neg_pulse_o <= 1'b0;
    end else begin
      sig_q       <= sig_i;
      pos_pulse_o <= rise_o;
      neg_pulse_o <= fall_o;
    end
  end
endmodule

// File: rtl/spi_byte_rx.sv
// SPI slave byte receiver (MSB first) with valid/ready output register and frame byte index.
// Optional sticky overflow flag enabled by defining SPI_BYTE_RX_OVF_EN.
module spi_byte_rx
  import spi_byte_rx_pkg::*;
#(
  parameter int BYTE_CNT_W = BYTE_CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  spi_sclk_pos_i,
  input  logic                  spi_mosi_i,
  input  logic                  spi_cs_n_i,
  input  logic                  byte_rdy_i,
  output logic                  byte_vld_o,
  output logic [BYTE_W-1:0]     byte_data_o,
  output logic [BYTE_CNT_W-1:0] byte_cnt_o,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic                  ovf_o
);
  logic                  cs_fall;
  logic                  cs_rise;
  logic                  armed_q;
  logic                  sample;
  logic                  byte_done;
  logic [2:0]            bit_cnt_q;
  spi_byte_t             shift_q;
  logic [BYTE_CNT_W-1:0] frame_cnt_q;

  spi_byte_rx_edge_detect u_edge_detect (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .sig_i       (spi_cs_n_i),
    .rise_o      (cs_rise),
    .fall_o      (cs_fall),
    .pos_pulse_o (frame_end_o),
    .neg_pulse_o (frame_start_o)
  );

  // The first low cycle of CS is the frame-start cycle and never samples.
  // armed_q blocks sampling after a reset taken with CS already low.
  assign sample    = spi_sclk_pos_i & ~spi_cs_n_i & ~cs_fall & armed_q;
  assign byte_done = sample & (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      armed_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
    end else begin
      if (spi_cs_n_i) armed_q <= 1'b1;
      if (spi_cs_n_i) begin
        bit_cnt_q <= 3'd0;
        shift_q   <= '0;
      end else if (sample) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= {shift_q[BYTE_W-2:0], spi_mosi_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_q <= '0;
      byte_vld_o  <= 1'b0;
      byte_data_o <= '0;
      byte_cnt_o  <= '0;
    end else begin
      if (cs_fall) begin
        frame_cnt_q <= '0;
      end else if (byte_done && frame_cnt_q != '1) begin
        frame_cnt_q <= frame_cnt_q + {{(BYTE_CNT_W-1){1'b0}}, 1'b1};
      end
      // A completing byte always wins, overwriting any unaccepted one.
      if (byte_done) begin
        byte_vld_o  <= 1'b1;
        byte_data_o <= {shift_q[BYTE_W-2:0], spi_mosi_i};
        byte_cnt_o  <= frame_cnt_q;
      end else if (byte_vld_o && byte_rdy_i) begin
        byte_vld_o <= 1'b0;
      end
    end
  end

`ifdef SPI_BYTE_RX_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else if (cs_fall) begin
      ovf_q <= 1'b0;
    end else if (byte_done && byte_vld_o && !byte_rdy_i) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  logic unused_rise;
  assign unused_rise = cs_rise;
endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: directed scenarios plus randomized frames vs a byte-level model.
module tb_spi_byte_rx;
  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          spi_sclk_pos_i;
  logic          spi_mosi_i;
  logic          spi_cs_n_i;
  logic          byte_rdy_i;
  logic          byte_vld_o;
  logic [7:0]    byte_data_o;
  logic [CW-1:0] byte_cnt_o;
  logic          frame_start_o;
  logic          frame_end_o;
  logic          ovf_o;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_cycles = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] got_data[$];
  int         got_cnt[$];

`ifdef SPI_BYTE_RX_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  spi_byte_rx #(.BYTE_CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .spi_sclk_pos_i (spi_sclk_pos_i),
    .spi_mosi_i     (spi_mosi_i),
    .spi_cs_n_i     (spi_cs_n_i),
    .byte_rdy_i     (byte_rdy_i),
    .byte_vld_o     (byte_vld_o),
    .byte_data_o    (byte_data_o),
    .byte_cnt_o     (byte_cnt_o),
    .frame_start_o  (frame_start_o),
    .frame_end_o    (frame_end_o),
    .ovf_o          (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor at the inactive edge: record accepted bytes and pulse counts.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (byte_vld_o) vld_cycles++;
      if (frame_start_o) fs_cnt++;
      if (frame_end_o) fe_cnt++;
      if (byte_vld_o && byte_rdy_i) begin
        got_data.push_back(byte_data_o);
        got_cnt.push_back(int'(byte_cnt_o));
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    spi_sclk_pos_i = 1'b1;
    spi_mosi_i     = b;
    tick();
    spi_sclk_pos_i = 1'b0;
    spi_mosi_i     = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic cs_low();
    spi_cs_n_i = 1'b0;
    tick(3);
  endtask

  task automatic cs_high();
    spi_cs_n_i = 1'b1;
    tick(3);
  endtask

  task automatic clear_log();
    got_data.delete();
    got_cnt.delete();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; spi_sclk_pos_i = 1'b0; spi_mosi_i = 1'b0;
    spi_cs_n_i = 1'b1; byte_rdy_i = 1'b1;
    tick(3);
    n_checks++;
    if ({byte_vld_o, byte_data_o, byte_cnt_o, frame_start_o, frame_end_o, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%b data=%h cnt=%0d fs=%b fe=%b ovf=%b, expected all zero",
               byte_vld_o, byte_data_o, byte_cnt_o, frame_start_o, frame_end_o, ovf_o);
    end
    rst_n_i = 1'b1;
    tick(2);
  endtask

  task automatic test_single_byte();
    int fs0;
    clear_log();
    fs0 = fs_cnt;
    cs_low();
    n_checks++;
    if (fs_cnt - fs0 !== 1) begin
      n_fail++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt - fs0);
    end
    send_byte(8'hA5);
    tick(2);
    n_checks++;
    if (got_data.size() !== 1 || vld_cycles == 0) begin
      n_fail++; $display("FAIL a5_byte_count: got %0d expected 1", got_data.size());
    end else begin
      n_checks++;
      if (got_data[0] !== 8'hA5 || got_cnt[0] !== 0) begin
        n_fail++; $display("FAIL a5_byte: got data=%h cnt=%0d expected data=a5 cnt=0", got_data[0], got_cnt[0]);
      end
    end
    n_checks++;
    if (byte_vld_o !== 1'b0) begin
      n_fail++; $display("FAIL a5_vld_clear: got %b expected 0", byte_vld_o);
    end
    cs_high();
  endtask

  task automatic test_three_bytes();
    int fe0;
    clear_log();
    cs_low();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    tick(2);
    n_checks++;
    if (got_data.size() !== 3) begin
      n_fail++; $display("FAIL three_byte_count: got %0d expected 3", got_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_data[i] !== 8'(i + 1) || got_cnt[i] !== i) begin
          n_fail++; $display("FAIL three_byte_%0d: got data=%h cnt=%0d expected data=%h cnt=%0d",
                             i, got_data[i], got_cnt[i], 8'(i + 1), i);
        end
      end
    end
    fe0 = fe_cnt;
    spi_cs_n_i = 1'b1;
    tick();
    n_checks++;
    if (frame_end_o !== 1'b1) begin
      n_fail++; $display("FAIL frame_end_timing: got %b expected 1", frame_end_o);
    end
    tick(3);
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin
      n_fail++; $display("FAIL frame_end_pulses: got %0d expected 1", fe_cnt - fe0);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    byte_rdy_i = 1'b0;
    cs_low();
    send_byte(8'h11); send_byte(8'h22);
    tick(2);
    n_checks++;
    if (byte_vld_o !== 1'b1 || byte_data_o !== 8'h22 || byte_cnt_o !== CW'(1)) begin
      n_fail++; $display("FAIL ovf_hold: got vld=%b data=%h cnt=%0d expected vld=1 data=22 cnt=1",
                         byte_vld_o, byte_data_o, byte_cnt_o);
    end
    n_checks++;
    if (ovf_o !== OVF_EXP) begin
      n_fail++; $display("FAIL ovf_flag: got %b expected %b", ovf_o, OVF_EXP);
    end
    byte_rdy_i = 1'b1;
    tick();
    n_checks++;
    if (byte_vld_o !== 1'b0 || got_data.size() !== 1) begin
      n_fail++; $display("FAIL ovf_accept: got vld=%b accepted=%0d expected vld=0 accepted=1",
                         byte_vld_o, got_data.size());
    end
    cs_high();
    n_checks++;
    if (ovf_o !== OVF_EXP) begin
      n_fail++; $display("FAIL ovf_sticky: got %b expected %b", ovf_o, OVF_EXP);
    end
    cs_low();
    n_checks++;
    if (ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf_o);
    end
    cs_high();
  endtask

  task automatic test_partial_discard();
    int v0;
    clear_log();
    v0 = vld_cycles;
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cs_high();
    n_checks++;
    if (vld_cycles !== v0) begin
      n_fail++; $display("FAIL partial_no_vld: got %0d vld cycles expected 0", vld_cycles - v0);
    end
    cs_low();
    send_byte(8'h3C);
    tick(2);
    n_checks++;
    if (got_data.size() !== 1 || got_data[0] !== 8'h3C || got_cnt[0] !== 0) begin
      n_fail++; $display("FAIL partial_next_byte: got n=%0d data=%h expected n=1 data=3c cnt=0",
                         got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'h00);
    end
    cs_high();
  endtask

  task automatic test_reset_mid_byte();
    clear_log();
    cs_low();
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst_n_i = 1'b0;
    tick();
    n_checks++;
    if ({byte_vld_o, byte_data_o, byte_cnt_o, ovf_o} !== '0) begin
      n_fail++; $display("FAIL reset_mid_state: got vld=%b data=%h cnt=%0d ovf=%b expected zero",
                         byte_vld_o, byte_data_o, byte_cnt_o, ovf_o);
    end
    rst_n_i = 1'b1;
    tick();
    clear_log();
    cs_high();
    cs_low();
    send_byte(8'hFF);
    tick(2);
    n_checks++;
    if (got_data.size() !== 1 || byte_data_o !== 8'hFF || byte_cnt_o !== CW'(0)) begin
      n_fail++; $display("FAIL reset_resume: got n=%0d data=%h cnt=%0d expected n=1 data=ff cnt=0",
                         got_data.size(), byte_data_o, byte_cnt_o);
    end
    cs_high();
  endtask

  task automatic test_sclk_cs_high();
    int v0;
    logic [7:0] d0;
    v0 = vld_cycles;
    d0 = byte_data_o;
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
    n_checks++;
    if (vld_cycles !== v0 || byte_vld_o !== 1'b0 || byte_data_o !== d0) begin
      n_fail++; $display("FAIL cs_high_ignored: got vld_cycles=%0d data=%h expected vld_cycles=0 data=%h",
                         vld_cycles - v0, byte_data_o, d0);
    end
  endtask

  // Model: each frame yields its bytes in order, index = min(position, all-ones).
  task automatic test_random_frames();
    logic [7:0] exp_data[$];
    int         exp_cnt[$];
    int         nb;
    logic [7:0] b;
    for (int f = 0; f < 6; f++) begin
      clear_log();
      exp_data.delete();
      exp_cnt.delete();
      nb = (f == 5) ? 10 : $urandom_range(1, 5);
      cs_low();
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        exp_data.push_back(b);
        exp_cnt.push_back((i < (1 << CW) - 1) ? i : (1 << CW) - 1);
        send_byte(b);
        tick($urandom_range(0, 3));
      end
      tick(2);
      cs_high();
      n_checks++;
      if (got_data.size() !== exp_data.size()) begin
        n_fail++; $display("FAIL rand_frame%0d_count: got %0d expected %0d", f, got_data.size(), exp_data.size());
      end else begin
        for (int i = 0; i < nb; i++) begin
          n_checks++;
          if (got_data[i] !== exp_data[i] || got_cnt[i] !== exp_cnt[i]) begin
            n_fail++; $display("FAIL rand_frame%0d_byte%0d: got data=%h cnt=%0d expected data=%h cnt=%0d",
                               f, i, got_data[i], got_cnt[i], exp_data[i], exp_cnt[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_three_bytes();
    test_overflow();
    test_partial_discard();
    test_reset_mid_byte();
    test_sclk_cs_high();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_byte_rx.md
SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have parameter: BYTE_CNT_W, 16, width of the per-frame byte counter.
REQ-002 SHALL have port: clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_n_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: spi_sclk_pos_i  input  1  one-cycle pulse per SCLK rising edge, already synchronized.
REQ-005 SHALL have port: spi_mosi_i  input  1  synchronized MOSI level, aligned with spi_sclk_pos_i.
REQ-006 SHALL have port: spi_cs_n_i  input  1  synchronized chip-select level, active low.
REQ-007 SHALL have port: byte_rdy_i  input  1  consumer accepts byte_data_o this cycle.
REQ-008 SHALL have port: byte_vld_o  output  1  byte_data_o holds an unaccepted byte.
REQ-009 SHALL have port: byte_data_o  output  8  received byte.
REQ-010 SHALL have port: byte_cnt_o  output  BYTE_CNT_W  index of byte_data_o within the current frame, first byte = 0.
REQ-011 SHALL have port: frame_start_o  output  1  one-cycle pulse on spi_cs_n_i falling edge.
REQ-012 SHALL have port: frame_end_o  output  1  one-cycle pulse on spi_cs_n_i rising edge.
REQ-013 SHALL have port: ovf_o  output  1  sticky overflow flag (see Configuration).

Function
REQ-014 SHALL sample spi_mosi_i into an 8-bit shift register, MSB first, only in cycles with spi_sclk_pos_i=1 and spi_cs_n_i=0.
REQ-015 SHALL keep a 3-bit bit counter, incremented per sample, wrapping 7->0.
REQ-016 SHALL, on the cycle after the 8th sample, load byte_data_o with the assembled byte, set byte_vld_o=1, and drive byte_cnt_o with the frame byte count before increment.
REQ-017 SHALL hold byte_vld_o, byte_data_o and byte_cnt_o stable until a cycle with byte_vld_o=1 and byte_rdy_i=1; byte_vld_o SHALL clear the following cycle unless a new byte completes in the same cycle, in which case the new byte SHALL be loaded with byte_vld_o kept at 1.
REQ-018 SHALL, when a byte completes while byte_vld_o=1 and byte_rdy_i=0, overwrite the output register with the new byte and raise the overflow condition.
REQ-019 SHALL clear the bit counter and shift register whenever spi_cs_n_i=1; a partial byte at deassertion SHALL be discarded with no byte_vld_o.
REQ-020 SHALL clear the frame byte counter on frame_start_o; the counter SHALL saturate at all-ones, not wrap.
REQ-021 SHALL generate frame_start_o and frame_end_o one cycle after the spi_cs_n_i transition; a pending byte_vld_o SHALL survive frame_end_o.
REQ-022 SHALL ignore spi_sclk_pos_i in the cycle where frame_start_o would be asserted; sampling begins the cycle after spi_cs_n_i is first seen low.

Reset
REQ-023 SHALL on rst_n_i=0 asynchronously clear all state: byte_vld_o=0, byte_data_o=0, byte_cnt_o=0, frame_start_o=0, frame_end_o=0, ovf_o=0, bit counter=0; internal CS history SHALL reset to 1 (deasserted).
REQ-024 SHALL, on reset mid-byte or mid-frame, discard all partial data and resume only on the next spi_cs_n_i falling edge.

Configuration
REQ-025 SHALL, with SPI_BYTE_RX_OVF_EN defined, set ovf_o sticky on the REQ-018 condition and clear it only on frame_start_o or reset.
REQ-026 SHALL, without SPI_BYTE_RX_OVF_EN, drive ovf_o constant 0 and omit the overflow logic; REQ-018 overwrite behaviour is unchanged.

Structure
REQ-027 SHALL place byte width (8) and default BYTE_CNT_W in a shared SPI package used by downstream consumers.
REQ-028 SHALL instantiate one edge_detect sub-module on spi_cs_n_i to derive frame_end_o (pos edge) and frame_start_o (neg edge).

Verification
REQ-029 SHALL cover: CS low, 8 SCLK pulses with MOSI 1,0,1,0,0,1,0,1, byte_rdy_i=1 -> one byte_vld_o pulse, byte_data_o=0xA5, byte_cnt_o=0.
REQ-030 SHALL cover: 3-byte frame 0x01,0x02,0x03 -> byte_cnt_o 0,1,2; frame_end_o one pulse after CS rise.
REQ-031 SHALL cover: byte_rdy_i=0 across 2 bytes 0x11,0x22 -> byte_data_o=0x22, ovf_o=1 (macro on) / 0 (macro off); next frame_start_o clears ovf_o.
REQ-032 SHALL cover: CS raised after 5 bits -> no byte_vld_o; next frame first byte 0x3C received intact.
REQ-033 SHALL cover: rst_n_i pulsed after 4 bits, then new frame sending 0xFF -> byte_data_o=0xFF, byte_cnt_o=0.
REQ-034 SHALL cover: SCLK pulses while CS high -> no state change, no byte_vld_o.
